cnt3_sched: RTL and testbench

Round-robin scheduler that shares one W-bit up/down counter datapath between two requesters. Each requester asks for a counting job: a direction plus a length. The block arbitrates, runs the counter for the granted job, flags terminal count, and returns a one-cycle done pulse. It sits between the counter consumers and the tff-based counter chains, and replaces ad-hoc direct drive of c3a/c3s-style counters.

---
 rtl/cnt3_sched.sv | 114 +++++++++++
 tb/tb_cnt3_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt3_sched.sv
// Round-robin scheduler sharing one W-bit up/down counter between two requesters.
// Jobs run len+1 counter steps, flag terminal count, then pulse done and idle for GAP cycles.
module cnt3_sched #(
    parameter int W   = 3,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         res,
    input  logic [1:0]   req,
    input  logic [1:0]   up,
    input  logic [W-1:0] len0,
    input  logic [W-1:0] len1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic [1:0]   done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_GAP} state_t;

    typedef struct packed {
        logic         own;
        logic         up;
        logic [W-1:0] len;
    } job_t;

    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t       state, nxt;
    job_t         job;
    logic         rr;
    logic [W-1:0] k;
    logic [3:0]   gcnt;
    logic         win, grant, step, leave;

    // with both requesting, the round-robin pointer picks the winner
    assign win = (req[0] && req[1]) ? rr : req[1];

    always_ff @(posedge clk) begin
        if (res) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt   = state;
        gnt   = 2'b00;
        busy  = 1'b0;
        tc    = 1'b0;
        done  = 2'b00;
        grant = 1'b0;
        step  = 1'b0;
        leave = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant = 1'b1;
                    nxt   = S_RUN;
                end
            end
            S_RUN: begin
                gnt  = job.own ? 2'b10 : 2'b01;
                busy = 1'b1;
                tc   = (k == job.len);
                // a dropped request aborts the job even on its final step
                if (!req[job.own]) begin
                    leave = 1'b1;
                    nxt   = (GAP > 0) ? S_GAP : S_IDLE;
                end else if (tc) begin
                    leave = 1'b1;
                    nxt   = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = job.own ? 2'b10 : 2'b01;
                nxt  = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                busy = 1'b1;
                if (gcnt == GAP_LAST) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            job  <= '0;
            rr   <= 1'b0;
            k    <= '0;
            gcnt <= '0;
            cnt  <= '0;
        end else begin
            if (grant) begin
                job.own <= win;
                job.up  <= up[win];
                job.len <= win ? len1 : len0;
                k       <= '0;
                cnt     <= up[win] ? '0 : '1;
            end
            if (step) begin
                k   <= k + 1'b1;
                cnt <= job.up ? cnt + 1'b1 : cnt - 1'b1;
            end
            if (leave) rr <= ~job.own;
            if (state == S_GAP) gcnt <= gcnt + 1'b1;
            else                gcnt <= '0;
        end
    end

endmodule

// File: tb/tb_cnt3_sched.sv
// Randomized scoreboard bench for cnt3_sched: driver queues expected jobs,
// monitor reconstructs each observed job and compares against the rule-derived reference.
module tb_cnt3_sched;

    localparam int W    = 3;
    localparam int GAP  = 1;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         res;
    logic [1:0]   req, up;
    logic [W-1:0] len0, len1;
    logic [1:0]   gnt, done;
    logic         busy, tc;
    logic [W-1:0] cnt;

    cnt3_sched #(.W(W), .GAP(GAP)) dut (
        .clk(clk), .res(res), .req(req), .up(up), .len0(len0), .len1(len1),
        .gnt(gnt), .busy(busy), .cnt(cnt), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int own;
        bit up;
        int len;
        int ab;     // abort step, -1 when the job runs to completion
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rr_m   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int expcnt(input bit u, input int k);
        return u ? (k & MASK) : ((MASK - k) & MASK);
    endfunction

    // monitor
    int   ph = 0, mk = 0, last = 0, bcnt = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!mon_en) begin
            ph = 0;
        end else begin
            chk("gnt_onehot0", int'($onehot0(gnt)), 1);
            chk("done_onehot0", int'($onehot0(done)), 1);
            chk("done_with_gnt", int'((done != 2'b00) && (gnt != 2'b00)), 0);
            chk("tc_without_gnt", int'(tc && (gnt == 2'b00)), 0);
            if (ph == 0 && gnt != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                    cur = '{own: 0, up: 1'b1, len: 0, ab: -1};
                end else begin
                    cur = sb.pop_front();
                end
                ph = 1;
                mk = 0;
            end
            if (ph == 1) begin
                if (gnt != 2'b00) begin
                    chk("gnt", int'(gnt), 1 << cur.own);
                    chk("busy_run", int'(busy), 1);
                    chk("cnt", int'(cnt), expcnt(cur.up, mk));
                    chk("tc", int'(tc), int'(mk == cur.len));
                    last = int'(cnt);
                    mk++;
                    if (mk > MASK + 2) begin
                        chk("run_overlong", mk, cur.len + 1);
                        ph = 0;
                    end
                end else begin
                    chk("run_steps", mk, (cur.ab < 0) ? cur.len + 1 : cur.ab + 1);
                    chk("done_end", int'(done), (cur.ab < 0) ? (1 << cur.own) : 0);
                    chk("cnt_hold", int'(cnt), last);
                    bcnt = int'(busy);
                    if (!busy) begin
                        chk("busy_cycles", bcnt, (cur.ab < 0) ? 1 + GAP : GAP);
                        ph = 0;
                    end else begin
                        ph = 2;
                    end
                end
            end else if (ph == 2) begin
                if (busy) begin
                    bcnt++;
                    chk("done_gap", int'(done), 0);
                    chk("gnt_gap", int'(gnt), 0);
                    chk("cnt_gap", int'(cnt), last);
                    if (bcnt > 40) begin
                        chk("busy_stuck", bcnt, 1 + GAP);
                        ph = 0;
                    end
                end else begin
                    chk("busy_cycles", bcnt, (cur.ab < 0) ? 1 + GAP : GAP);
                    ph = 0;
                end
            end
        end
    end

    // driver: issues one job from IDLE and plays the requester until the block is idle again
    task automatic run_job(input logic [1:0] pat, input logic [1:0] upv,
                           input int l0, input int l1, input int ab_in);
        int   w, L, ab, n;
        exp_t e;
        @(negedge clk);
        w  = (pat == 2'b11) ? rr_m : ((pat == 2'b10) ? 1 : 0);
        L  = w ? l1 : l0;
        ab = (ab_in >= L) ? -1 : ab_in;
        req  = pat;
        up   = upv;
        len0 = W'(l0);
        len1 = W'(l1);
        e.own = w; e.up = upv[w]; e.len = L; e.ab = ab;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("latency_gnt", int'(gnt), 1 << w);
        // inputs other than the winner's req must be ignored from here on
        req[1-w] = 1'b0;
        up   = 2'($urandom);
        len0 = W'($urandom);
        len1 = W'($urandom);
        if (ab >= 0) begin
            repeat (ab) @(posedge clk);
            #1 req[w] = 1'b0;
        end else begin
            n = 0;
            do begin @(negedge clk); n++; end while (!done[w] && n < 40);
            chk("done_seen", int'(done[w]), 1);
            req[w] = 1'b0;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 40);
        chk("idle_after_job", int'(busy), 0);
        rr_m = 1 - w;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        int n;
        res = 1'b1; req = 2'b00; up = 2'b00; len0 = '0; len1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_done", int'(done), 0);
        res = 1'b0;
        mon_en = 1'b1;

        run_job(2'b01, 2'b01, 5, 0, -1);
        run_job(2'b10, 2'b00, 0, 3, -1);
        run_job(2'b11, 2'b11, 1, 2, -1);
        run_job(2'b11, 2'b11, 1, 2, -1);
        run_job(2'b11, 2'b11, 3, 4, -1);
        run_job(2'b01, 2'b01, 0, 0, -1);
        run_job(2'b01, 2'b00, 7, 0, -1);
        run_job(2'b01, 2'b11, 7, 0, -1);
        run_job(2'b01, 2'b01, 6, 0, 3);
        run_job(2'b11, 2'b11, 2, 1, -1);
        run_job(2'b01, 2'b01, 2, 0, -1);

        // reset mid-run: pointer currently favours requester 1
        @(negedge clk);
        mon_en = 1'b0;
        req = 2'b01; up = 2'b01; len0 = 3'd6;
        n = 0;
        do begin @(negedge clk); n++; end while (cnt != 3'd4 && n < 20);
        chk("rst_reach4", int'(cnt), 4);
        res = 1'b1;
        req = 2'b00;
        @(negedge clk);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cnt", int'(cnt), 0);
        chk("midrst_tc", int'(tc), 0);
        chk("midrst_done", int'(done), 0);
        res = 1'b0;
        sb.delete();
        rr_m = 0;
        @(negedge clk);
        mon_en = 1'b1;
        run_job(2'b11, 2'b01, 2, 3, -1);

        for (int i = 0; i < 200; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MASK)) : -1;
            run_job(2'($urandom_range(1, 3)), 2'($urandom),
                    int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), ab);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
